uart_tx: RTL and testbench

- UART transmitter: serialises 8-bit bytes onto the TX line as 8N1 frames, or 8E1 when parity is compiled in.
- Pairs with the CPU's UART instruction-load receiver. Used to stream Data_mem / Accumulator contents back to the host after HLT.
- Single clock domain, with a one-byte holding buffer so the next byte can be queued while the current frame shifts.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_if.sv | 29 ++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: state encoding, frame constants, line levels
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLK_FREQ     = 100_000_000;
    localparam int DEFAULT_BAUD_RATE    = 9600;
    localparam int DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD_RATE;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake and serial line bundle for the UART transmitter
interface uart_tx_if;

    logic                           Send;
    logic [uart_pkg::DATA_BITS-1:0] Data_in;
    logic                           Ready;
    logic                           TX;
    logic                           Busy;
    logic                           Done;

    modport master (
        output Send,
        output Data_in,
        input  Ready,
        input  TX,
        input  Busy,
        input  Done
    );

    modport slave (
        input  Send,
        input  Data_in,
        output Ready,
        output TX,
        output Busy,
        output Done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - per-bit cycle counter with clear; bit_tick marks the last cycle of a bit
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    output logic bit_tick_o,
    output logic pre_tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick_o = (cnt_q == LAST_CNT);
    // Lets the owner register a strobe that lines up with the final cycle of a bit
    assign pre_tick_o = (cnt_q == PRE_CNT);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8N1 frames with one-byte holding buffer; UART_TX_PARITY_EN adds even parity (8E1)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE    = DEFAULT_BAUD_RATE,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic     Clk,
    input  logic     Reset,
    uart_tx_if.slave bus
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic                 tx_q;
    logic                 done_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic bit_tick;
    logic pre_tick;
    logic accept;
    logic load_now;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk       (Clk),
        .resetn    (Reset),
        .clear_i   (state_q == ST_IDLE),
        .bit_tick_o(bit_tick),
        .pre_tick_o(pre_tick)
    );

    assign accept   = bus.Send && !hold_full_q;
    // A queued byte starts immediately from IDLE or straight after the stop bit, so frames abut
    assign load_now = hold_full_q &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_tick));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            tx_q        <= IDLE_LEVEL;
            done_q      <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            done_q <= (state_q == ST_STOP) && pre_tick;

            if (accept) begin
                hold_q      <= bus.Data_in;
                hold_full_q <= 1'b1;
            end

            if (load_now) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                bit_cnt_q   <= '0;
                state_q     <= ST_START;
                tx_q        <= START_LEVEL;
`ifdef UART_TX_PARITY_EN
                parity_q    <= even_parity(hold_q);
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        tx_q <= IDLE_LEVEL;
                    end
                    ST_START: begin
                        if (bit_tick) begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                            bit_cnt_q <= '0;
                            state_q   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bit_tick) begin
                            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                                tx_q    <= parity_q;
                                state_q <= ST_PARITY;
`else
                                tx_q    <= STOP_LEVEL;
                                state_q <= ST_STOP;
`endif
                            end else begin
                                tx_q      <= shift_q[0];
                                shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        if (bit_tick) begin
                            tx_q    <= STOP_LEVEL;
                            state_q <= ST_STOP;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (bit_tick) begin
                            tx_q    <= IDLE_LEVEL;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        tx_q    <= IDLE_LEVEL;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.Ready = ~hold_full_q;
    assign bus.TX    = tx_q;
    assign bus.Busy  = (state_q != ST_IDLE) | hold_full_q;
    assign bus.Done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx at CLKS_PER_BIT=4, 8N1 or 8E1 with UART_TX_PARITY_EN
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] sb[$];

    uart_tx_if u_if ();

    uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Clk  (clk),
        .Reset(resetn),
        .bus  (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        u_if.Send    = 1'b1;
        u_if.Data_in = b;
        while (u_if.Ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (u_if.Ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept byte=%h Ready=%b required 1", b, u_if.Ready);
        end else begin
            sb.push_back(b);
        end
        @(negedge clk);
        u_if.Send = 1'b0;
    endtask

    task automatic recv_frame(output int waited, output int start_cyc, output int done_cyc);
        logic [7:0]       exp_b;
        logic [NBITS-1:0] lv;
        logic             exp_done;
        waited    = 0;
        start_cyc = -1;
        done_cyc  = -1;
        @(negedge clk);
        while (u_if.TX !== 1'b0 && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (u_if.TX !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_timeout TX=%b required 0", u_if.TX);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty frame seen with queue size 0, required >0");
            return;
        end
        exp_b = sb.pop_front();
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) lv[i+1] = exp_b[i];
`ifdef UART_TX_PARITY_EN
        lv[9] = ^exp_b;
`endif
        lv[NBITS-1] = 1'b1;
        start_cyc = cyc;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (u_if.TX !== lv[c/CPB]) begin
                errors++;
                $display("FAIL tx_level byte=%h bit=%0d cycle=%0d got %b required %b",
                         exp_b, c / CPB, c, u_if.TX, lv[c/CPB]);
            end
            exp_done = (c == FRAME_CYC - 1);
            checks++;
            if (u_if.Done !== exp_done) begin
                errors++;
                $display("FAIL done_pulse byte=%h cycle=%0d got %b required %b",
                         exp_b, c, u_if.Done, exp_done);
            end
            if (u_if.Done === 1'b1) done_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        u_if.Send    = 1'b1;
        u_if.Data_in = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({u_if.TX, u_if.Ready, u_if.Busy, u_if.Done} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_outputs TX/Ready/Busy/Done=%b required 1100",
                         {u_if.TX, u_if.Ready, u_if.Busy, u_if.Done});
            end
        end
        u_if.Send = 1'b0;
        resetn    = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({u_if.TX, u_if.Ready, u_if.Busy} !== 3'b110) begin
            errors++;
            $display("FAIL reset_nothing_accepted TX/Ready/Busy=%b required 110",
                     {u_if.TX, u_if.Ready, u_if.Busy});
        end
    endtask

    task automatic test_single();
        int w, s, d;
        send_byte(8'hA5);
        checks++;
        if (u_if.TX !== 1'b1) begin
            errors++;
            $display("FAIL single_latency TX=%b required 1 before start edge", u_if.TX);
        end
        recv_frame(w, s, d);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL single_start_latency waited=%0d required 0", w);
        end
        checks++;
        if (d - s !== FRAME_CYC - 1) begin
            errors++;
            $display("FAIL single_done_position got %0d required %0d", d - s, FRAME_CYC - 1);
        end
        @(negedge clk);
        checks++;
        if (u_if.Busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_after Busy=%b required 0", u_if.Busy);
        end
    endtask

    task automatic test_back_to_back();
        int w1, s1, d1, w2, s2, d2, n;
        fork
            begin
                send_byte(8'h3C);
                send_byte(8'hC3);
                n = 0;
                while (u_if.Ready !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (n !== FRAME_CYC - 1) begin
                    errors++;
                    $display("FAIL b2b_ready_low cycles=%0d required %0d", n, FRAME_CYC - 1);
                end
            end
            begin
                recv_frame(w1, s1, d1);
                recv_frame(w2, s2, d2);
            end
        join
        checks++;
        if (w2 !== 0) begin
            errors++;
            $display("FAIL b2b_idle_gap got %0d required 0", w2);
        end
        checks++;
        if (d2 - d1 !== FRAME_CYC) begin
            errors++;
            $display("FAIL b2b_done_spacing got %0d required %0d", d2 - d1, FRAME_CYC);
        end
    endtask

    task automatic test_send_held();
        int acc, guard, w, s, d;
        acc   = 0;
        guard = 0;
        fork
            begin
                u_if.Send    = 1'b1;
                u_if.Data_in = 8'($urandom);
                while (acc < 3 && guard < 500) begin
                    if (u_if.Ready === 1'b1) begin
                        sb.push_back(u_if.Data_in);
                        acc++;
                    end
                    @(negedge clk);
                    guard++;
                    u_if.Data_in = 8'($urandom);
                end
                u_if.Send = 1'b0;
            end
            begin
                repeat (3) recv_frame(w, s, d);
            end
        join
        checks++;
        if (acc !== 3) begin
            errors++;
            $display("FAIL held_accepts got %0d required 3", acc);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL held_leftover queue=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int w, s, d;
        send_byte(8'h55);
        repeat (18) @(negedge clk);
        checks++;
        if (u_if.TX !== 1'b0) begin
            errors++;
            $display("FAIL midframe_bit3 TX=%b required 0", u_if.TX);
        end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({u_if.TX, u_if.Ready, u_if.Busy, u_if.Done} !== 4'b1100) begin
            errors++;
            $display("FAIL midframe_reset TX/Ready/Busy/Done=%b required 1100",
                     {u_if.TX, u_if.Ready, u_if.Busy, u_if.Done});
        end
        resetn = 1'b1;
        if (sb.size() != 0) void'(sb.pop_front());
        send_byte(8'h0F);
        recv_frame(w, s, d);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL midframe_restart waited=%0d required 0", w);
        end
    endtask

    task automatic test_frame_length();
        int w, s, d;
        logic [7:0] pat [2];
        pat[0] = 8'h07;
        pat[1] = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            send_byte(pat[i]);
            recv_frame(w, s, d);
            checks++;
            if (d - s + 1 !== FRAME_CYC) begin
                errors++;
                $display("FAIL frame_length byte=%h got %0d required %0d", pat[i], d - s + 1, FRAME_CYC);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        u_if.Send    = 1'b0;
        u_if.Data_in = 8'h00;
        resetn       = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_send_held();
        test_reset_mid_frame();
        test_frame_length();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
